// File: rtl/router_local_port_if.sv
// Link and crossbar signal bundle for router_local_port.
// The master side is the router endpoint itself; the slave side is the
// environment (NIC link plus router crossbar).
interface router_local_port_if;
  logic        polarity;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ro;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ri;
  logic        xb_req_vld;
  logic [63:0] xb_req_data;
  logic        xb_req_gnt;
  logic        xb_dlv_vld;
  logic [63:0] xb_dlv_data;
  logic        xb_dlv_rdy;
  logic        vc_err;

  modport master (
    output polarity,
    input  net_so, net_do,
    output net_ro,
    output net_si, net_di,
    input  net_ri,
    output xb_req_vld, xb_req_data,
    input  xb_req_gnt,
    input  xb_dlv_vld, xb_dlv_data,
    output xb_dlv_rdy,
    output vc_err
  );

  modport slave (
    input  polarity,
    output net_so, net_do,
    input  net_ro,
    input  net_si, net_di,
    output net_ri,
    input  xb_req_vld, xb_req_data,
    output xb_req_gnt,
    output xb_dlv_vld, xb_dlv_data,
    input  xb_dlv_rdy,
    input  vc_err
  );
endinterface

// File: rtl/router_local_port.sv
// router_local_port: router-side endpoint of the NIC-to-router link.
// One 64-bit packet buffer per VC per direction. The link serves VC
// 'polarity' while the crossbar serves the other VC, so both sides can
// transfer in the same cycle without touching the same buffer.
// Optional feature: define LOCAL_PORT_VC_CHECK_EN to drop NIC packets whose
// bit 63 disagrees with the current polarity and raise a sticky vc_err.
module router_local_port (
  input  logic                 clk,
  input  logic                 reset,
  router_local_port_if.master  port
);

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  phase_t      phase;

  logic [63:0] in_buf  [2];
  logic [1:0]  in_full;
  logic [63:0] out_buf [2];
  logic [1:0]  out_full;

  logic        p;
  logic        q;
  logic        link_in_take;
  logic        link_in_store;
  logic        link_out_take;
  logic        xb_in_take;
  logic        xb_out_take;
  logic        vc_bad;

  // Phase decode: link VC and crossbar VC are always opposite.
  always_comb begin
    p = (phase == PH_ODD);
    q = ~p;
  end

  // Handshake decode and combinational outputs, all from registers plus
  // the partner's handshake inputs.
  always_comb begin
    port.polarity    = p;
    port.net_ro      = ~in_full[p];
    port.net_si      = out_full[p] & port.net_ri;
    port.net_di      = '0;
    if (out_full[p] && port.net_ri)
      port.net_di    = out_buf[p];
    port.xb_req_vld  = in_full[q];
    port.xb_req_data = '0;
    if (in_full[q])
      port.xb_req_data = in_buf[q];
    port.xb_dlv_rdy  = ~out_full[q];

    link_in_take  = port.net_so & ~in_full[p];
    link_out_take = out_full[p] & port.net_ri;
    xb_in_take    = in_full[q] & port.xb_req_gnt;
    xb_out_take   = port.xb_dlv_vld & ~out_full[q];

`ifdef LOCAL_PORT_VC_CHECK_EN
    vc_bad        = port.net_do[63] != p;
`else
    vc_bad        = 1'b0;
`endif
    link_in_store = link_in_take & ~vc_bad;
  end

  // Link phase register: toggles every cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= PH_EVEN;
    end else begin
      phase <= (phase == PH_EVEN) ? PH_ODD : PH_EVEN;
    end
  end

  // Inbound buffers: filled from the link on VC p, drained by crossbar on VC q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_full   <= '0;
      in_buf[0] <= '0;
      in_buf[1] <= '0;
    end else begin
      if (link_in_store) begin
        in_buf[p]  <= port.net_do;
        in_full[p] <= 1'b1;
      end
      if (xb_in_take) begin
        in_full[q] <= 1'b0;
      end
    end
  end

  // Outbound buffers: filled by crossbar on VC q, drained to the link on VC p.
  // A delivery whose bit 63 disagrees with q is still stored under q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_full   <= '0;
      out_buf[0] <= '0;
      out_buf[1] <= '0;
    end else begin
      if (xb_out_take) begin
        out_buf[q]  <= port.xb_dlv_data;
        out_full[q] <= 1'b1;
      end
      if (link_out_take) begin
        out_full[p] <= 1'b0;
      end
    end
  end

`ifdef LOCAL_PORT_VC_CHECK_EN
  logic vc_err_q;

  // Sticky VC-mismatch flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc_err_q <= 1'b0;
    end else if (link_in_take && vc_bad) begin
      vc_err_q <= 1'b1;
    end
  end

  // Drive the flag onto the bundle.
  always_comb begin
    port.vc_err = vc_err_q;
  end
`else
  // Mismatch checking disabled: flag held low.
  always_comb begin
    port.vc_err = 1'b0;
  end
`endif

endmodule
